// File: rtl/frame_transmitter.sv
// frame_transmitter: buffers a 1..MAX_WORDS payload and emits
// HEADER|CHAN|DATA|CRC|TRAILER frames on a 16-bit word bus.
//
// Ports:
//   clk_in, rst_n (async, active low)
//   start / start_ready    frame request handshake, IDLE only
//   channel, len_words     one-hot channel and payload length,
//                          sampled on an accepted start
//   crc_inject             send ~crc (FRAME_TX_CRC_INJ_EN only)
//   s_data/s_valid/s_ready payload load, first word is the MSW
//   data_out, frame_act    framed word stream and frame strobe
//   done                   pulse on the last trailer word
//   cfg_err                pulse after a rejected start
//
// Build option: FRAME_TX_CRC_INJ_EN adds the crc_inject port.
module frame_transmitter #(
  parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
  parameter logic [31:0] TRAILER   = 32'h0E0E0E0E,
  parameter int          MAX_WORDS = 8,
  parameter int          GAP_WORDS = 1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        start,
  output logic        start_ready,
  input  logic [7:0]  channel,
  input  logic [3:0]  len_words,
`ifdef FRAME_TX_CRC_INJ_EN
  input  logic        crc_inject,
`endif
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] data_out,
  output logic        frame_act,
  output logic        done,
  output logic        cfg_err
);

  localparam int IW =
    (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int GW =
    (GAP_WORDS > 1) ? $clog2(GAP_WORDS) : 1;
  localparam logic [3:0] LEN_MAX = 4'(MAX_WORDS);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_HDR_H,
    S_HDR_L,
    S_CHAN,
    S_DATA,
    S_CRC,
    S_TRL_H,
    S_TRL_L,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   mem_q [MAX_WORDS];
  logic [7:0]    chan_q;
  logic [3:0]    len_q;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   crc_q, crc_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   crc_tx;
  logic          idle;
  logic          cfg_ok;
  logic          last_idx;

  // Parallel form of the MSB-first XMODEM shift:
  // with a 16-bit word the data folds into the
  // register up front, then 16 plain shifts.
  function automatic logic [15:0] crc16_upd(
    input logic [15:0] c,
    input logic [15:0] w
  );
    logic [15:0] r;
    r = c ^ w;
    for (int i = 0; i < 16; i++) begin
      if (r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else       r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign idle        = (state_q == S_IDLE);
  assign start_ready = idle;
  assign s_ready     = (state_q == S_LOAD);
  assign last_idx    = (idx_q == (len_q - 4'd1));

  // One-hot: non-zero with no second bit set.
  assign cfg_ok =
    (channel != 8'h00) &&
    ((channel & (channel - 8'h01)) == 8'h00) &&
    (len_words != 4'h0) &&
    (len_words <= LEN_MAX);

`ifdef FRAME_TX_CRC_INJ_EN
  logic inj_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= 1'b0;
    end else if (idle && start && cfg_ok) begin
      inj_q <= crc_inject;
    end
  end

  assign crc_tx = inj_q ? ~crc_q : crc_q;
`else
  assign crc_tx = crc_q;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    gap_d     = gap_q;
    data_out  = 16'h0000;
    frame_act = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          state_d = S_LOAD;
          idx_d   = 4'd0;
          crc_d   = 16'h0000;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          crc_d = crc16_upd(crc_q, s_data);
          if (last_idx) begin
            state_d = S_HDR_H;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_HDR_H: begin
        data_out  = HEADER[31:16];
        frame_act = 1'b1;
        state_d   = S_HDR_L;
      end
      S_HDR_L: begin
        data_out  = HEADER[15:0];
        frame_act = 1'b1;
        state_d   = S_CHAN;
      end
      S_CHAN: begin
        data_out  = {8'h00, chan_q};
        frame_act = 1'b1;
        state_d   = S_DATA;
      end
      S_DATA: begin
        data_out  = mem_q[idx_q[IW-1:0]];
        frame_act = 1'b1;
        if (last_idx) begin
          state_d = S_CRC;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_CRC: begin
        data_out  = crc_tx;
        frame_act = 1'b1;
        state_d   = S_TRL_H;
      end
      S_TRL_H: begin
        data_out  = TRAILER[31:16];
        frame_act = 1'b1;
        state_d   = S_TRL_L;
      end
      S_TRL_L: begin
        data_out  = TRAILER[15:0];
        frame_act = 1'b1;
        done      = 1'b1;
        state_d   = S_GAP;
        gap_d     = '0;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      crc_q   <= 16'h0000;
      gap_q   <= '0;
      chan_q  <= 8'h00;
      len_q   <= 4'd0;
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      gap_q   <= gap_d;
      cfg_err <= idle && start && !cfg_ok;
      if (idle && start && cfg_ok) begin
        chan_q <= channel;
        len_q  <= len_words;
      end
    end
  end

  // Payload store; stale contents are harmless
  // because every word is rewritten before use.
  always_ff @(posedge clk_in) begin
    if (s_ready && s_valid) begin
      mem_q[idx_q[IW-1:0]] <= s_data;
    end
  end

endmodule
